// File: rtl/intr_timer_ctrl.sv
`default_nettype none
// =============================================================================
// intr_timer_ctrl : M-mode interrupt source (mtime/mtimecmp, msip, external line)
// Revision 1.0 : initial release
// =============================================================================
module intr_timer_ctrl #(
  parameter logic [15:0] TICK_DIV = 16'd50,
  parameter bit          EXT_EDGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_we,
  input  logic [3:0]  io_wadr,
  input  logic [31:0] io_wdata,
  input  logic        io_re,
  input  logic [3:0]  io_radr,
  output logic [31:0] io_rdata,
  input  logic        ext_irq,
  input  logic        csr_rmie,
  input  logic        csr_meie,
  input  logic        csr_mtie,
  input  logic        csr_msie,
  input  logic        cmd_mret_ex,
  input  logic        stall,
  output logic        g_interrupt,
  output logic [1:0]  g_interrupt_priv,
  output logic [1:0]  int_src,
  output logic [2:0]  mip_bits
);

  localparam logic [3:0]  c_adr_mtime_lo = 4'd0;
  localparam logic [3:0]  c_adr_mtime_hi = 4'd1;
  localparam logic [3:0]  c_adr_cmp_lo   = 4'd2;
  localparam logic [3:0]  c_adr_cmp_hi   = 4'd3;
  localparam logic [3:0]  c_adr_msip     = 4'd4;
  localparam logic [3:0]  c_adr_ext_pend = 4'd5;
  localparam logic [15:0] c_tick_last    = TICK_DIV - 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        ext_pend_q, ext_pend_d;
  logic        sync1_q, sync2_q, ext_prev_q;
  logic [1:0]  int_src_q, int_src_d;
  logic [31:0] rdata_q, rdata_d;

  logic        w_tick;
  logic        w_wr_mtime_lo, w_wr_mtime_hi, w_wr_cmp_lo, w_wr_cmp_hi;
  logic        w_wr_msip, w_wr_ext_pend;
  logic        w_ext_rise;
  logic        w_mtip;
  logic [1:0]  w_cand;
  logic        w_req;
  logic [31:0] w_rd_mux;

  assign w_wr_mtime_lo = io_we && (io_wadr == c_adr_mtime_lo);
  assign w_wr_mtime_hi = io_we && (io_wadr == c_adr_mtime_hi);
  assign w_wr_cmp_lo   = io_we && (io_wadr == c_adr_cmp_lo);
  assign w_wr_cmp_hi   = io_we && (io_wadr == c_adr_cmp_hi);
  assign w_wr_msip     = io_we && (io_wadr == c_adr_msip);
  assign w_wr_ext_pend = io_we && (io_wadr == c_adr_ext_pend);

  assign w_tick     = (presc_q == c_tick_last);
  assign w_ext_rise = sync2_q & ~ext_prev_q;
  assign w_mtip     = (mtime_q >= mtimecmp_q);

  // A software write to either mtime half suppresses that cycle's increment entirely.
  always_comb begin
    presc_d    = w_tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (w_wr_mtime_lo) begin
      mtime_d[31:0] = io_wdata;
    end else if (w_wr_mtime_hi) begin
      mtime_d[63:32] = io_wdata;
    end else if (w_tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (w_wr_cmp_lo) mtimecmp_d[31:0]  = io_wdata;
    if (w_wr_cmp_hi) mtimecmp_d[63:32] = io_wdata;
    if (w_wr_msip)   msip_d            = io_wdata[0];
  end

  always_comb begin
    ext_pend_d = ext_pend_q;
    if (EXT_EDGE) begin
      if (w_wr_ext_pend && io_wdata[0]) ext_pend_d = 1'b0;
      if (w_ext_rise)                   ext_pend_d = 1'b1;
    end else begin
      ext_pend_d = sync2_q;
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (io_radr)
      c_adr_mtime_lo: w_rd_mux = mtime_q[31:0];
      c_adr_mtime_hi: w_rd_mux = mtime_q[63:32];
      c_adr_cmp_lo:   w_rd_mux = mtimecmp_q[31:0];
      c_adr_cmp_hi:   w_rd_mux = mtimecmp_q[63:32];
      c_adr_msip:     w_rd_mux = {31'd0, msip_q};
      c_adr_ext_pend: w_rd_mux = {31'd0, ext_pend_q};
      default:        w_rd_mux = 32'd0;
    endcase
    rdata_d = io_re ? w_rd_mux : rdata_q;
  end

  always_comb begin
    w_cand = 2'd0;
    if (ext_pend_q && csr_meie)      w_cand = 2'd1;
    else if (msip_q && csr_msie)     w_cand = 2'd2;
    else if (w_mtip && csr_mtie)     w_cand = 2'd3;
    w_req = (w_cand != 2'd0) && csr_rmie;
  end

  // Sources are never cleared here; the handler must quiesce them before mret.
  always_comb begin
    state_d     = state_q;
    int_src_d   = int_src_q;
    g_interrupt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_req && !stall) begin
          state_d   = ST_FIRE;
          int_src_d = w_cand;
        end
      end
      ST_FIRE: begin
        g_interrupt = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd_mret_ex) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      ext_pend_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      ext_prev_q <= 1'b0;
      int_src_q  <= 2'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      ext_pend_q <= ext_pend_d;
      sync1_q    <= ext_irq;
      sync2_q    <= sync1_q;
      ext_prev_q <= sync2_q;
      int_src_q  <= int_src_d;
      rdata_q    <= rdata_d;
    end
  end

  assign io_rdata         = rdata_q;
  assign int_src          = int_src_q;
  assign g_interrupt_priv = 2'b11;
  assign mip_bits         = {ext_pend_q, w_mtip, msip_q};

endmodule
`default_nettype wire
